// File: rtl/reservation_alu3_scheduler.sv
// ALU3 reservation station controller: allocates entries, generates in-order
// execution tags, picks a ready entry and holds it in a one-deep issue register.
module reservation_alu3_scheduler #(
   parameter int ENTRY_N = 4,
   parameter int INFO_W  = 118
) (
   input  logic                        iCLOCK,
   input  logic                        inRESET,
   input  logic                        iFLUSH,
   input  logic                        iREGIST_REQ,
   output logic                        oREGIST_ACK,
   output logic                        oREGIST_FULL,
   output logic [ENTRY_N-1:0]          oREGIST_VALID,
   output logic [3:0]                  oREGIST_EX_POINTER,
   output logic [3:0]                  oEX_EXECUTION_POINTER,
   output logic                        oREMOVE_VALID,
   input  logic [ENTRY_N-1:0]          iENTRY_VALID,
   input  logic [ENTRY_N-1:0]          iENTRY_MATCHING,
   input  logic [ENTRY_N*INFO_W-1:0]   iENTRY_INFO,
   output logic [ENTRY_N-1:0]          oEXOUT_VALID,
   output logic                        oALU_VALID,
   input  logic                        iALU_BUSY,
   output logic [INFO_W-1:0]           oALU_INFO,
   output logic                        oEMPTY
);

   logic [3:0]         registPtr;
   logic [3:0]         execPtr;
   logic               outValid;
   logic [INFO_W-1:0]  aluInfo;

   logic [ENTRY_N-1:0] freeVec;
   logic [ENTRY_N-1:0] freeOneHot;
   logic               freeFound;
   logic [ENTRY_N-1:0] candVec;
   logic [ENTRY_N-1:0] selOneHot;
   logic               selFound;
   logic [INFO_W-1:0]  selInfo;
   logic               regAck;
   logic               canLoad;
   logic               issue;

   assign freeVec = ~iENTRY_VALID;
   assign candVec = iENTRY_VALID & iENTRY_MATCHING;

   // Lowest-index priority pick for both allocation and issue selection.
   always_comb begin
      freeOneHot = '0;
      freeFound  = 1'b0;
      selOneHot  = '0;
      selFound   = 1'b0;
      selInfo    = '0;
      for (int i = 0; i < ENTRY_N; i++) begin
         if (freeVec[i] && !freeFound) begin
            freeOneHot[i] = 1'b1;
            freeFound     = 1'b1;
         end
         if (candVec[i] && !selFound) begin
            selOneHot[i] = 1'b1;
            selFound     = 1'b1;
            selInfo      = iENTRY_INFO[i*INFO_W +: INFO_W];
         end
      end
   end

   assign oREGIST_FULL  = &iENTRY_VALID;
   assign regAck        = iREGIST_REQ & ~oREGIST_FULL & ~iFLUSH;
   assign canLoad       = ~outValid | ~iALU_BUSY;
   assign issue         = selFound & canLoad & ~iFLUSH;

   assign oREGIST_ACK           = regAck;
   assign oREGIST_VALID         = regAck ? freeOneHot : '0;
   assign oREGIST_EX_POINTER    = registPtr;
   assign oEX_EXECUTION_POINTER = execPtr;
   assign oREMOVE_VALID         = iFLUSH;
   assign oEXOUT_VALID          = issue ? selOneHot : '0;
   assign oALU_VALID            = outValid;
   assign oALU_INFO             = aluInfo;
   assign oEMPTY                = ~|iENTRY_VALID & ~outValid;

   // Flush wins over everything; otherwise a new issue refills the output
   // register in the same cycle the previous operation drains.
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         registPtr <= 4'd0;
         execPtr   <= 4'd0;
         outValid  <= 1'b0;
         aluInfo   <= '0;
      end else if (iFLUSH) begin
         registPtr <= 4'd0;
         execPtr   <= 4'd0;
         outValid  <= 1'b0;
      end else begin
         if (regAck) begin
            registPtr <= registPtr + 4'd1;
         end
         if (issue) begin
            aluInfo  <= selInfo;
            outValid <= 1'b1;
            execPtr  <= execPtr + 4'd1;
         end else if (outValid && !iALU_BUSY) begin
            outValid <= 1'b0;
         end
      end
   end

endmodule
